// File: rtl/cpu_param.sv
// Parametrised multi-cycle core: FSM controller, 8-entry register file, shifter/ALU.
// One 16-bit instruction runs per start pulse; illegal opcodes set a sticky flag.
module cpu_param #(
  parameter int DATA_W = 16,
  parameter bit ASR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              ill
);
  localparam int MSB = DATA_W - 1;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] sub;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_t;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WB
  } state_t;

  state_t            state, nxt;
  instr_t            ir;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] a, b, c, bs, alu, imm, diff;
  logic [7:0]        im8;
  logic              is_movi, is_movr, is_add, is_cmp, is_and, is_mvn, legal;

  assign is_movi = (ir.op == 3'b110) && (ir.sub == 2'b10);
  assign is_movr = (ir.op == 3'b110) && (ir.sub == 2'b00);
  assign is_add  = (ir.op == 3'b101) && (ir.sub == 2'b00);
  assign is_cmp  = (ir.op == 3'b101) && (ir.sub == 2'b01);
  assign is_and  = (ir.op == 3'b101) && (ir.sub == 2'b10);
  assign is_mvn  = (ir.op == 3'b101) && (ir.sub == 2'b11);
  assign legal   = is_movi | is_movr | is_add | is_cmp | is_and | is_mvn;

  // im8 overlaps the Rd/sh/Rm fields
  assign im8 = {ir.rd, ir.sh, ir.rm};
  assign imm = DATA_W'($signed(im8));

  always_comb begin
    bs = b;
    case (ir.sh)
      2'b01:   bs = {b[MSB-1:0], 1'b0};
      2'b10:   bs = {1'b0, b[MSB:1]};
      2'b11:   bs = {ASR_EN & b[MSB], b[MSB:1]};
      default: bs = b;
    endcase
  end

  assign diff = a - bs;

  always_comb begin
    alu = bs;
    if (is_add)      alu = a + bs;
    else if (is_and) alu = a & bs;
    else if (is_mvn) alu = ~bs;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_WAIT;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT:   if (s) nxt = S_DECODE;
      S_DECODE: begin
        if (is_movi)                           nxt = S_WIMM;
        else if (is_movr | is_mvn)             nxt = S_GETB;
        else if (is_add | is_and | is_cmp)     nxt = S_GETA;
        else                                   nxt = S_WAIT;
      end
      S_WIMM:   nxt = S_WAIT;
      S_GETA:   nxt = S_GETB;
      S_GETB:   nxt = S_EXEC;
      S_EXEC:   nxt = is_cmp ? S_WAIT : S_WB;
      S_WB:     nxt = S_WAIT;
      default:  nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      c   <= '0;
      N   <= 1'b0;
      V   <= 1'b0;
      Z   <= 1'b0;
      ill <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (state == S_WAIT && load) ir <= instr_t'(in);
      case (state)
        S_DECODE: if (!legal) ill <= 1'b1;
        S_WIMM:   rf[ir.rn] <= imm;
        S_GETA:   a <= rf[ir.rn];
        S_GETB:   b <= rf[ir.rm];
        S_EXEC: begin
          // CMP touches only the flags; C keeps the last real result
          if (is_cmp) begin
            Z <= (diff == '0);
            N <= diff[MSB];
            V <= (a[MSB] != bs[MSB]) && (diff[MSB] != a[MSB]);
          end else begin
            c <= alu;
          end
        end
        S_WB:     rf[ir.rd] <= c;
        default: ;
      endcase
    end
  end

  assign out = c;
  assign w   = (state == S_WAIT);
endmodule
